// File: rtl/axi4_pkg.sv
// axi4_pkg: slice mode/fill-state enums and per-channel payload width helpers for axi4_reg_slice
package axi4_pkg;
  typedef enum logic [1:0] {SLICE_BYPASS, SLICE_FWD, SLICE_REV, SLICE_FULL} slice_mode_e;
  typedef enum logic [1:0] {FILL_EMPTY, FILL_ONE, FILL_TWO} fill_e;
  function automatic int clamp1(input int w);
    return w > 0 ? w : 1;
  endfunction
  function automatic int aw_payload_w(input int id_w, input int addr_w, input int user_w);
    return clamp1(id_w) + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + clamp1(user_w);
  endfunction
  function automatic int ar_payload_w(input int id_w, input int addr_w, input int user_w);
    return clamp1(id_w) + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + clamp1(user_w);
  endfunction
  function automatic int w_payload_w(input int id_w, input int n_bytes, input int user_w);
    return clamp1(id_w) + 8 * n_bytes + n_bytes + 1 + clamp1(user_w);
  endfunction
  function automatic int b_payload_w(input int id_w, input int user_w);
    return clamp1(id_w) + 2 + clamp1(user_w);
  endfunction
  function automatic int r_payload_w(input int id_w, input int n_bytes, input int user_w);
    return clamp1(id_w) + 8 * n_bytes + 2 + 1 + clamp1(user_w);
  endfunction
endpackage

// File: rtl/axi4_if.sv
// axi4_if: AXI4 bundle (ACLK/ARESETn ports) with master and slave modports; zero ID/user widths become 1
interface axi4_if #(
  parameter int N_BYTES      = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int ID_WIDTH     = 4,
  parameter int AWUSER_WIDTH = 0,
  parameter int WUSER_WIDTH  = 0,
  parameter int BUSER_WIDTH  = 0,
  parameter int ARUSER_WIDTH = 0,
  parameter int RUSER_WIDTH  = 0
) (
  input logic ACLK,
  input logic ARESETn
);
  localparam int IW   = ID_WIDTH > 0 ? ID_WIDTH : 1;
  localparam int AWUW = AWUSER_WIDTH > 0 ? AWUSER_WIDTH : 1;
  localparam int WUW  = WUSER_WIDTH > 0 ? WUSER_WIDTH : 1;
  localparam int BUW  = BUSER_WIDTH > 0 ? BUSER_WIDTH : 1;
  localparam int ARUW = ARUSER_WIDTH > 0 ? ARUSER_WIDTH : 1;
  localparam int RUW  = RUSER_WIDTH > 0 ? RUSER_WIDTH : 1;
  logic [IW-1:0]         AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;
  logic [3:0]            AWREGION;
  logic [AWUW-1:0]       AWUSER;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [IW-1:0]         WID;
  logic [8*N_BYTES-1:0]  WDATA;
  logic [N_BYTES-1:0]    WSTRB;
  logic                  WLAST;
  logic [WUW-1:0]        WUSER;
  logic                  WVALID;
  logic                  WREADY;
  logic [IW-1:0]         BID;
  logic [1:0]            BRESP;
  logic [BUW-1:0]        BUSER;
  logic                  BVALID;
  logic                  BREADY;
  logic [IW-1:0]         ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic [3:0]            ARREGION;
  logic [ARUW-1:0]       ARUSER;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [IW-1:0]         RID;
  logic [8*N_BYTES-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [RUW-1:0]        RUSER;
  logic                  RVALID;
  logic                  RREADY;
  modport master (
    input  ACLK, ARESETn,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );
  modport slave (
    input  ACLK, ARESETn,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WUSER, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_reg_slice_chan.sv
// axi4_reg_slice_chan: one valid/ready channel stage (bypass/forward/reverse/2-entry full), busy when a beat is held
module axi4_reg_slice_chan
  import axi4_pkg::*;
#(
  parameter int          WIDTH = 1,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic unused_clk;
    assign unused_clk = ACLK ^ ARESET;
    assign out_valid  = in_valid;
    assign in_ready   = out_ready;
    assign out_data   = in_data;
    assign busy       = 1'b0;
  end else if (MODE == SLICE_FWD) begin : g_fwd
    logic             ov;
    logic [WIDTH-1:0] od;
    assign in_ready  = !ov || out_ready;
    assign out_valid = ov;
    assign out_data  = od;
    assign busy      = ov;
    always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) ov <= 1'b0;
      else if (in_ready) ov <= in_valid;
    always_ff @(posedge ACLK)
      if (in_valid && in_ready) od <= in_data;
  end else if (MODE == SLICE_REV) begin : g_rev
    logic             live;
    logic             sv;
    logic [WIDTH-1:0] sd;
    // live holds valid/ready low until the first edge after reset so no beat is seen on one side only
    assign in_ready  = live && !sv;
    assign out_valid = sv || (live && in_valid);
    assign out_data  = sv ? sd : in_data;
    assign busy      = sv;
    always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
        live <= 1'b0;
        sv   <= 1'b0;
      end else begin
        live <= 1'b1;
        sv   <= !out_ready && (sv || (in_valid && in_ready));
      end
    always_ff @(posedge ACLK)
      if (in_valid && in_ready && !out_ready) sd <= in_data;
  end else begin : g_full
    fill_e            state;
    fill_e            state_nxt;
    logic             live;
    logic             in_hs;
    logic             out_hs;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign out_data = head;
    assign busy     = state != FILL_EMPTY;
    always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
        state <= FILL_EMPTY;
        live  <= 1'b0;
      end else begin
        state <= state_nxt;
        live  <= 1'b1;
      end
    always_comb begin
      state_nxt = state;
      in_ready  = live && state != FILL_TWO;
      out_valid = state != FILL_EMPTY;
      state_nxt = state == FILL_EMPTY ? (in_hs ? FILL_ONE : FILL_EMPTY)
                : state == FILL_ONE   ? (in_hs && !out_hs ? FILL_TWO : !in_hs && out_hs ? FILL_EMPTY : FILL_ONE)
                :                       (out_hs ? FILL_ONE : FILL_TWO);
    end
    // head is always the beat on the output; tail only fills when a second beat arrives behind a stalled head
    always_ff @(posedge ACLK)
      if (state == FILL_TWO) begin
        if (out_hs) head <= tail;
      end else if (in_hs) begin
        if (state == FILL_EMPTY || out_hs) head <= in_data;
        else tail <= in_data;
      end
  end
endmodule

// File: rtl/axi4_reg_slice.sv
// axi4_reg_slice: AXI4 register slice, s (upstream) to m (downstream), per-channel mode, busy when any beat buffered
module axi4_reg_slice
  import axi4_pkg::*;
#(
  parameter int N_BYTES      = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int ID_WIDTH     = 4,
  parameter int AWUSER_WIDTH = 0,
  parameter int WUSER_WIDTH  = 0,
  parameter int BUSER_WIDTH  = 0,
  parameter int ARUSER_WIDTH = 0,
  parameter int RUSER_WIDTH  = 0,
  parameter int AW_MODE      = 3,
  parameter int W_MODE       = 3,
  parameter int B_MODE       = 3,
  parameter int AR_MODE      = 3,
  parameter int R_MODE       = 3
) (
  input  logic   ACLK,
  input  logic   ARESET,
  axi4_if.slave  s,
  axi4_if.master m,
  output logic   busy
);
  localparam int AW_W = aw_payload_w(ID_WIDTH, ADDR_WIDTH, AWUSER_WIDTH);
  localparam int W_W  = w_payload_w(ID_WIDTH, N_BYTES, WUSER_WIDTH);
  localparam int B_W  = b_payload_w(ID_WIDTH, BUSER_WIDTH);
  localparam int AR_W = ar_payload_w(ID_WIDTH, ADDR_WIDTH, ARUSER_WIDTH);
  localparam int R_W  = r_payload_w(ID_WIDTH, N_BYTES, RUSER_WIDTH);
  localparam logic [1:0] AWM = AW_MODE[1:0];
  localparam logic [1:0] WM  = W_MODE[1:0];
  localparam logic [1:0] BM  = B_MODE[1:0];
  localparam logic [1:0] ARM = AR_MODE[1:0];
  localparam logic [1:0] RM  = R_MODE[1:0];
  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in, r_out;
  logic            aw_busy, w_busy, b_busy, ar_busy, r_busy;
  logic            unused_if;
  assign unused_if = ^{s.ACLK, s.ARESETn, m.ACLK, m.ARESETn};
  assign aw_in = {s.AWID, s.AWADDR, s.AWLEN, s.AWSIZE, s.AWBURST, s.AWLOCK, s.AWCACHE, s.AWPROT, s.AWQOS, s.AWREGION, s.AWUSER};
  assign {m.AWID, m.AWADDR, m.AWLEN, m.AWSIZE, m.AWBURST, m.AWLOCK, m.AWCACHE, m.AWPROT, m.AWQOS, m.AWREGION, m.AWUSER} = aw_out;
  assign w_in = {s.WID, s.WDATA, s.WSTRB, s.WLAST, s.WUSER};
  assign {m.WID, m.WDATA, m.WSTRB, m.WLAST, m.WUSER} = w_out;
  assign b_in = {m.BID, m.BRESP, m.BUSER};
  assign {s.BID, s.BRESP, s.BUSER} = b_out;
  assign ar_in = {s.ARID, s.ARADDR, s.ARLEN, s.ARSIZE, s.ARBURST, s.ARLOCK, s.ARCACHE, s.ARPROT, s.ARQOS, s.ARREGION, s.ARUSER};
  assign {m.ARID, m.ARADDR, m.ARLEN, m.ARSIZE, m.ARBURST, m.ARLOCK, m.ARCACHE, m.ARPROT, m.ARQOS, m.ARREGION, m.ARUSER} = ar_out;
  assign r_in = {m.RID, m.RDATA, m.RRESP, m.RLAST, m.RUSER};
  assign {s.RID, s.RDATA, s.RRESP, s.RLAST, s.RUSER} = r_out;
  assign busy = aw_busy | w_busy | b_busy | ar_busy | r_busy;
  axi4_reg_slice_chan #(.WIDTH(AW_W), .MODE(slice_mode_e'(AWM))) u_aw (
    .ACLK, .ARESET,
    .in_valid(s.AWVALID), .in_ready(s.AWREADY), .in_data(aw_in),
    .out_valid(m.AWVALID), .out_ready(m.AWREADY), .out_data(aw_out), .busy(aw_busy)
  );
  axi4_reg_slice_chan #(.WIDTH(W_W), .MODE(slice_mode_e'(WM))) u_w (
    .ACLK, .ARESET,
    .in_valid(s.WVALID), .in_ready(s.WREADY), .in_data(w_in),
    .out_valid(m.WVALID), .out_ready(m.WREADY), .out_data(w_out), .busy(w_busy)
  );
  axi4_reg_slice_chan #(.WIDTH(B_W), .MODE(slice_mode_e'(BM))) u_b (
    .ACLK, .ARESET,
    .in_valid(m.BVALID), .in_ready(m.BREADY), .in_data(b_in),
    .out_valid(s.BVALID), .out_ready(s.BREADY), .out_data(b_out), .busy(b_busy)
  );
  axi4_reg_slice_chan #(.WIDTH(AR_W), .MODE(slice_mode_e'(ARM))) u_ar (
    .ACLK, .ARESET,
    .in_valid(s.ARVALID), .in_ready(s.ARREADY), .in_data(ar_in),
    .out_valid(m.ARVALID), .out_ready(m.ARREADY), .out_data(ar_out), .busy(ar_busy)
  );
  axi4_reg_slice_chan #(.WIDTH(R_W), .MODE(slice_mode_e'(RM))) u_r (
    .ACLK, .ARESET,
    .in_valid(m.RVALID), .in_ready(m.RREADY), .in_data(r_in),
    .out_valid(s.RVALID), .out_ready(s.RREADY), .out_data(r_out), .busy(r_busy)
  );
endmodule

// File: tb/tb_axi4_reg_slice.sv
// tb_axi4_reg_slice: randomized self-checking bench, AW bypass, W/AR full, B forward, R reverse
module tb_axi4_reg_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstn;
  logic busy;
  int   n_cmp = 0;
  int   n_fail = 0;
  assign rstn = !rst;
  always #5 clk = ~clk;
  axi4_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s_if (.ACLK(clk), .ARESETn(rstn));
  axi4_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) m_if (.ACLK(clk), .ARESETn(rstn));
  axi4_reg_slice #(
    .N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4),
    .AW_MODE(0), .W_MODE(3), .B_MODE(1), .AR_MODE(3), .R_MODE(2)
  ) dut (.ACLK(clk), .ARESET(rst), .s(s_if), .m(m_if), .busy(busy));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic init_sigs;
    {s_if.AWID, s_if.AWADDR, s_if.AWLEN, s_if.AWSIZE, s_if.AWBURST, s_if.AWLOCK, s_if.AWCACHE} = '0;
    {s_if.AWPROT, s_if.AWQOS, s_if.AWREGION, s_if.AWUSER, s_if.AWVALID} = '0;
    {s_if.WID, s_if.WDATA, s_if.WSTRB, s_if.WLAST, s_if.WUSER, s_if.WVALID} = '0;
    {s_if.ARID, s_if.ARADDR, s_if.ARLEN, s_if.ARSIZE, s_if.ARBURST, s_if.ARLOCK, s_if.ARCACHE} = '0;
    {s_if.ARPROT, s_if.ARQOS, s_if.ARREGION, s_if.ARUSER, s_if.ARVALID} = '0;
    {s_if.BREADY, s_if.RREADY} = '0;
    {m_if.AWREADY, m_if.WREADY, m_if.ARREADY} = '0;
    {m_if.BID, m_if.BRESP, m_if.BUSER, m_if.BVALID} = '0;
    {m_if.RID, m_if.RDATA, m_if.RRESP, m_if.RLAST, m_if.RUSER, m_if.RVALID} = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    init_sigs();
    repeat (3) begin
      step();
      n_cmp++;
      if ({m_if.AWVALID, m_if.WVALID, m_if.ARVALID, s_if.BVALID, s_if.RVALID} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_valids: got %b want 00000", {m_if.AWVALID, m_if.WVALID, m_if.ARVALID, s_if.BVALID, s_if.RVALID});
      end
      n_cmp++;
      if ({s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.RREADY} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_readys: got %b want 0000", {s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.RREADY});
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({s_if.WREADY, s_if.ARREADY, m_if.RREADY} !== 3'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b want 000", {s_if.WREADY, s_if.ARREADY, m_if.RREADY});
    end
    step();
    m_if.AWREADY = 1'b1;
    #1;
    n_cmp++;
    if ({s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.BREADY, m_if.RREADY} !== 5'b11111) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b want 11111", {s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.BREADY, m_if.RREADY});
    end
    m_if.AWREADY = 1'b0;
  endtask

  task automatic test_ar_stream;
    logic [3:0] ide[8];
    logic [7:0] lene[8];
    step();
    m_if.ARREADY = 1'b1;
    #1;
    n_cmp++;
    if (m_if.ARVALID !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got %b want 0", m_if.ARVALID); end
    for (int i = 0; i < 8; i++) begin
      ide[i] = 4'($urandom);
      lene[i] = 8'($urandom);
      s_if.ARVALID = 1'b1;
      s_if.ARADDR = 12'h100 + 12'(i);
      s_if.ARID = ide[i];
      s_if.ARLEN = lene[i];
      #1;
      n_cmp++;
      if (s_if.ARREADY !== 1'b1) begin n_fail++; $display("FAIL ar_ready beat %0d: got %b want 1", i, s_if.ARREADY); end
      step();
      n_cmp++;
      if ({m_if.ARVALID, m_if.ARADDR, m_if.ARID, m_if.ARLEN} !== {1'b1, 12'h100 + 12'(i), ide[i], lene[i]}) begin
        n_fail++;
        $display("FAIL ar_beat %0d: got v=%b a=%h id=%h len=%h want v=1 a=%h id=%h len=%h", i, m_if.ARVALID,
                 m_if.ARADDR, m_if.ARID, m_if.ARLEN, 12'h100 + 12'(i), ide[i], lene[i]);
      end
    end
    s_if.ARVALID = 1'b0;
    step();
    n_cmp++;
    if (m_if.ARVALID !== 1'b0) begin n_fail++; $display("FAIL ar_end: got %b want 0", m_if.ARVALID); end
    m_if.ARREADY = 1'b0;
  endtask

  task automatic test_w_stall;
    logic [31:0] wd[4];
    int          acc = 0;
    int          got = 0;
    int          bound = 20;
    logic        ih;
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    step();
    m_if.WREADY = 1'b0;
    repeat (6) begin
      s_if.WVALID = acc < 4;
      s_if.WDATA = wd[acc];
      s_if.WLAST = acc == 3;
      #1;
      ih = s_if.WVALID && s_if.WREADY;
      if (m_if.WVALID) begin
        n_cmp++;
        if (m_if.WDATA !== wd[0]) begin n_fail++; $display("FAIL w_hold: got %h want %h", m_if.WDATA, wd[0]); end
      end
      step();
      if (ih) acc++;
    end
    n_cmp++;
    if (acc !== 2) begin n_fail++; $display("FAIL w_accepted: got %0d want 2", acc); end
    n_cmp++;
    if ({s_if.WREADY, m_if.WVALID, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL w_full_flags: got wready/wvalid/busy %b want 011", {s_if.WREADY, m_if.WVALID, busy});
    end
    m_if.WREADY = 1'b1;
    while (got < 4 && bound > 0) begin
      s_if.WVALID = acc < 4;
      s_if.WDATA = wd[acc < 4 ? acc : 3];
      s_if.WLAST = acc == 3;
      #1;
      ih = s_if.WVALID && s_if.WREADY;
      if (m_if.WVALID && m_if.WREADY) begin
        n_cmp++;
        if ({m_if.WDATA, m_if.WLAST} !== {wd[got], got == 3}) begin
          n_fail++;
          $display("FAIL w_drain beat %0d: got %h/%b want %h/%b", got, m_if.WDATA, m_if.WLAST, wd[got], got == 3);
        end
        got++;
      end
      step();
      if (ih) acc++;
      bound--;
    end
    s_if.WVALID = 1'b0;
    s_if.WLAST = 1'b0;
    #1;
    n_cmp++;
    if (got !== 4) begin n_fail++; $display("FAIL w_drain_count: got %0d want 4", got); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL w_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_r_reverse;
    logic [31:0] rd[24];
    int          ic = 0;
    int          oc = 0;
    int          bound = 5;
    logic        ih;
    for (int i = 0; i < 24; i++) rd[i] = $urandom;
    step();
    for (int c = 0; c < 16; c++) begin
      s_if.RREADY = c % 2 == 0;
      m_if.RVALID = 1'b1;
      m_if.RDATA = rd[ic];
      m_if.RID = 4'(ic);
      #1;
      n_cmp++;
      if (m_if.RREADY !== (ic == oc)) begin
        n_fail++;
        $display("FAIL r_ready cycle %0d: got %b want %b", c, m_if.RREADY, ic == oc);
      end
      n_cmp++;
      if (s_if.RVALID !== 1'b1) begin n_fail++; $display("FAIL r_valid cycle %0d: got %b want 1", c, s_if.RVALID); end
      ih = m_if.RVALID && m_if.RREADY;
      if (s_if.RVALID && s_if.RREADY) begin
        n_cmp++;
        if ({s_if.RDATA, s_if.RID} !== {rd[oc], 4'(oc)}) begin
          n_fail++;
          $display("FAIL r_data beat %0d: got %h id %h want %h id %h", oc, s_if.RDATA, s_if.RID, rd[oc], 4'(oc));
        end
        oc++;
      end
      step();
      if (ih) ic++;
    end
    m_if.RVALID = 1'b0;
    s_if.RREADY = 1'b1;
    while (oc < ic && bound > 0) begin
      #1;
      if (s_if.RVALID) begin
        n_cmp++;
        if (s_if.RDATA !== rd[oc]) begin n_fail++; $display("FAIL r_drain beat %0d: got %h want %h", oc, s_if.RDATA, rd[oc]); end
        oc++;
      end
      step();
      bound--;
    end
    n_cmp++;
    if (ic !== 9 || oc !== 9) begin n_fail++; $display("FAIL r_counts: got in %0d out %0d want 9/9", ic, oc); end
    s_if.RREADY = 1'b0;
  endtask

  task automatic test_aw_bypass;
    logic [11:0] a;
    logic [3:0]  id;
    logic        rdy;
    step();
    for (int i = 0; i < 6; i++) begin
      a = i == 0 ? 12'hABC : 12'($urandom);
      id = 4'($urandom);
      rdy = 1'($urandom);
      s_if.AWVALID = 1'b1;
      s_if.AWADDR = a;
      s_if.AWID = id;
      m_if.AWREADY = rdy;
      #1;
      n_cmp++;
      if ({m_if.AWVALID, m_if.AWADDR, m_if.AWID, s_if.AWREADY} !== {1'b1, a, id, rdy}) begin
        n_fail++;
        $display("FAIL aw_bypass %0d: got v=%b a=%h id=%h rdy=%b want v=1 a=%h id=%h rdy=%b", i, m_if.AWVALID,
                 m_if.AWADDR, m_if.AWID, s_if.AWREADY, a, id, rdy);
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL aw_busy %0d: got %b want 0", i, busy); end
      step();
    end
    s_if.AWVALID = 1'b0;
    m_if.AWREADY = 1'b0;
  endtask

  task automatic test_b_fwd;
    logic [5:0] be[64];
    int         ic = 0;
    int         oc = 0;
    int         bound = 4;
    logic       vld = 1'b0;
    logic       ih;
    for (int i = 0; i < 64; i++) be[i] = 6'($urandom);
    step();
    for (int c = 0; c < 60; c++) begin
      if (!vld) vld = $urandom % 3 != 0;
      m_if.BVALID = vld;
      {m_if.BID, m_if.BRESP} = be[ic];
      s_if.BREADY = 1'($urandom);
      #1;
      n_cmp++;
      if ({s_if.BVALID, busy} !== {2{ic != oc}}) begin
        n_fail++;
        $display("FAIL b_held cycle %0d: got bvalid/busy %b want %b", c, {s_if.BVALID, busy}, {2{ic != oc}});
      end
      n_cmp++;
      if (m_if.BREADY !== (ic == oc || s_if.BREADY)) begin
        n_fail++;
        $display("FAIL b_ready cycle %0d: got %b want %b", c, m_if.BREADY, ic == oc || s_if.BREADY);
      end
      ih = m_if.BVALID && m_if.BREADY;
      if (s_if.BVALID && s_if.BREADY) begin
        n_cmp++;
        if ({s_if.BID, s_if.BRESP} !== be[oc]) begin
          n_fail++;
          $display("FAIL b_data beat %0d: got %h want %h", oc, {s_if.BID, s_if.BRESP}, be[oc]);
        end
        oc++;
      end
      step();
      if (ih) begin ic++; vld = 1'b0; end
    end
    m_if.BVALID = 1'b0;
    s_if.BREADY = 1'b1;
    while (oc < ic && bound > 0) begin
      #1;
      if (s_if.BVALID) begin
        n_cmp++;
        if ({s_if.BID, s_if.BRESP} !== be[oc]) begin n_fail++; $display("FAIL b_drain beat %0d: got %h want %h", oc, {s_if.BID, s_if.BRESP}, be[oc]); end
        oc++;
      end
      step();
      bound--;
    end
    n_cmp++;
    if (oc !== ic || ic < 10) begin n_fail++; $display("FAIL b_counts: got in %0d out %0d want equal and >=10", ic, oc); end
    s_if.BREADY = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [32:0] we[96];
    int          ic = 0;
    int          oc = 0;
    int          bound = 5;
    logic        vld = 1'b0;
    logic        ih;
    for (int i = 0; i < 96; i++) we[i] = {1'($urandom), $urandom};
    step();
    for (int c = 0; c < 80; c++) begin
      if (!vld) vld = $urandom % 4 != 0;
      s_if.WVALID = vld;
      {s_if.WLAST, s_if.WDATA} = we[ic];
      m_if.WREADY = $urandom % 3 != 0;
      #1;
      n_cmp++;
      if ({s_if.WREADY, m_if.WVALID} !== {ic - oc < 2, ic != oc}) begin
        n_fail++;
        $display("FAIL w_occupancy cycle %0d: got wready/wvalid %b want %b", c, {s_if.WREADY, m_if.WVALID}, {ic - oc < 2, ic != oc});
      end
      ih = s_if.WVALID && s_if.WREADY;
      if (m_if.WVALID && m_if.WREADY) begin
        n_cmp++;
        if ({m_if.WLAST, m_if.WDATA} !== we[oc]) begin
          n_fail++;
          $display("FAIL w_order beat %0d: got %h want %h", oc, {m_if.WLAST, m_if.WDATA}, we[oc]);
        end
        oc++;
      end
      step();
      if (ih) begin ic++; vld = 1'b0; end
    end
    s_if.WVALID = 1'b0;
    m_if.WREADY = 1'b1;
    while (oc < ic && bound > 0) begin
      #1;
      if (m_if.WVALID) begin
        n_cmp++;
        if ({m_if.WLAST, m_if.WDATA} !== we[oc]) begin n_fail++; $display("FAIL w_tail beat %0d: got %h want %h", oc, {m_if.WLAST, m_if.WDATA}, we[oc]); end
        oc++;
      end
      step();
      bound--;
    end
    n_cmp++;
    if (oc !== ic || ic < 20 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL w_b2b_end: got in %0d out %0d busy %b want equal, >=20, busy 0", ic, oc, busy);
    end
    m_if.WREADY = 1'b0;
    s_if.WLAST = 1'b0;
  endtask

  task automatic test_reset_mid;
    step();
    m_if.WREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_if.WVALID = 1'b1;
      s_if.WDATA = $urandom;
      step();
    end
    s_if.WVALID = 1'b0;
    #1;
    n_cmp++;
    if ({m_if.WVALID, busy, s_if.WREADY} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_pre: got wvalid/busy/wready %b want 110", {m_if.WVALID, busy, s_if.WREADY});
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_if.WVALID, busy, s_if.WREADY} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: got wvalid/busy/wready %b want 000", {m_if.WVALID, busy, s_if.WREADY});
    end
    step();
    step();
    rst = 1'b0;
    m_if.WREADY = 1'b1;
    repeat (3) begin
      step();
      n_cmp++;
      if ({m_if.WVALID, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_ghost: got wvalid/busy %b want 00", {m_if.WVALID, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ar_stream();
    test_w_stall();
    test_r_reverse();
    test_aw_bypass();
    test_b_fwd();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
